// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, command prefixes and DDRAM wrap constants for lcd_responder.
// Contents: lcd_state_t, CMD_* prefix bytes (decoded by magnitude = highest set bit),
//           WRAP_* line boundaries, next_addr() address stepping with line wrap.
package lcd_pkg;

    typedef enum logic [2:0] {
        INIT_3A, INIT_3B, INIT_3C, INIT_2, HI_NIB, LO_NIB, BUSY
    } lcd_state_t;

    localparam logic [7:0] CMD_SET_DDRAM   = 8'h80;
    localparam logic [7:0] CMD_SET_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_FUNC_SET    = 8'h20;
    localparam logic [7:0] CMD_SHIFT       = 8'h10;
    localparam logic [7:0] CMD_DISP_CTRL   = 8'h08;
    localparam logic [7:0] CMD_ENTRY_MODE  = 8'h04;
    localparam logic [7:0] CMD_RETURN_HOME = 8'h02;
    localparam logic [7:0] CMD_CLEAR       = 8'h01;

    localparam logic [6:0] WRAP_L1_END   = 7'h27;
    localparam logic [6:0] WRAP_L2_START = 7'h40;
    localparam logic [6:0] WRAP_L2_END   = 7'h67;

    // The two display lines form one 80-character ring: 0x27 <-> 0x40 and 0x67 <-> 0x00.
    function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
        return inc ? ((a == WRAP_L1_END) ? WRAP_L2_START : (a == WRAP_L2_END) ? 7'h00 : a + 7'd1)
                   : ((a == WRAP_L2_START) ? WRAP_L1_END : (a == 7'h00) ? WRAP_L2_END : a - 7'd1);
    endfunction

endpackage

// File: rtl/lcd_frame_buffer.sv
// lcd_frame_buffer: 32x8 visible-character store for lcd_responder.
// Ports: i_clk clock; i_we/i_addr/i_data DDRAM write; i_clear fills every entry with 0x20;
//        i_rd_addr/o_rd_char registered read port (1-cycle latency).
// DDRAM 0x00-0x0F -> entries 0-15, 0x40-0x4F -> entries 16-31; other addresses are not stored.
module lcd_frame_buffer (
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_clear,
    input  logic [4:0] i_rd_addr,
    output logic [7:0] o_rd_char
);
    logic [7:0] r_mem [32];
    logic       w_hit;
    logic [4:0] w_idx;

    // Both visible windows have address bits [5:4] clear; bit 6 selects the line.
    assign w_hit = (i_addr[5:4] == 2'b00);
    assign w_idx = {i_addr[6], i_addr[3:0]};

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= 8'h20;
        end else if (i_we && w_hit) begin
            r_mem[w_idx] <= i_data;
        end
        o_rd_char <= r_mem[i_rd_addr];
    end
endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style 4-bit bus responder (init check, byte assembly, command decode, busy model).
// Ports: Clock, Reset (async active-low); iLCD_* asynchronous LCD bus inputs;
//        oByteValid/oByte/oIsData accepted byte; oDdramAddr, oBusy, oInitDone, oDispCtrl,
//        oProtocolError (sticky); iRdAddr/oRdChar frame-buffer read port.
// Option: define LCD_RESPONDER_FRAMEBUF_EN to include the lcd_frame_buffer; otherwise oRdChar is 0.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int CMD_BUSY_CYCLES   = 2000,
    parameter int CLEAR_BUSY_CYCLES = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RegisterSelect,
    input  logic       iLCD_ReadWrite,
    input  logic [3:0] iLCD_Data,
    output logic       oByteValid,
    output logic [7:0] oByte,
    output logic       oIsData,
    output logic [6:0] oDdramAddr,
    output logic       oBusy,
    output logic       oInitDone,
    output logic [2:0] oDispCtrl,
    output logic       oProtocolError,
    input  logic [4:0] iRdAddr,
    output logic [7:0] oRdChar
);
    localparam int MAXC = (CLEAR_BUSY_CYCLES > CMD_BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : CMD_BUSY_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [1:0]    r_e_s, r_rs_s, r_rw_s;
    logic [3:0]    r_d_s0, r_d_s1;
    logic          r_e_prev;
    lcd_state_t    r_state;
    logic [3:0]    r_hi;
    logic          r_rs_hi;
    logic          r_id;
    logic [CW-1:0] r_cnt;

    logic       w_rs, w_rw, w_strobe, w_stb, w_complete, w_clr_cmd, w_we, w_clear;
    logic [7:0] w_byte;

    assign w_rs       = r_rs_s[1];
    assign w_rw       = r_rw_s[1];
    assign w_strobe   = r_e_prev && !r_e_s[1];
    assign w_stb      = w_strobe && !w_rw;
    assign w_byte     = {r_hi, r_d_s1};
    assign w_complete = w_stb && (r_state == LO_NIB) && (w_rs == r_rs_hi);
    // Clear Display (0x01) and Return Home (0x02/0x03) take the long busy time.
    assign w_clr_cmd  = !w_rs && (w_byte != 8'h00) && (w_byte < CMD_ENTRY_MODE);
    assign w_we       = w_complete && w_rs;
    assign w_clear    = w_complete && !w_rs && (w_byte == CMD_CLEAR);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_e_s          <= '0;
            r_rs_s         <= '0;
            r_rw_s         <= '0;
            r_d_s0         <= '0;
            r_d_s1         <= '0;
            r_e_prev       <= 1'b0;
            r_state        <= INIT_3A;
            r_hi           <= '0;
            r_rs_hi        <= 1'b0;
            r_id           <= 1'b1;
            r_cnt          <= '0;
            oByteValid     <= 1'b0;
            oByte          <= '0;
            oIsData        <= 1'b0;
            oDdramAddr     <= '0;
            oBusy          <= 1'b0;
            oInitDone      <= 1'b0;
            oDispCtrl      <= '0;
            oProtocolError <= 1'b0;
        end else begin
            r_e_s      <= {r_e_s[0], iLCD_Enabled};
            r_rs_s     <= {r_rs_s[0], iLCD_RegisterSelect};
            r_rw_s     <= {r_rw_s[0], iLCD_ReadWrite};
            r_d_s0     <= iLCD_Data;
            r_d_s1     <= r_d_s0;
            r_e_prev   <= r_e_s[1];
            oByteValid <= 1'b0;
            if (w_strobe && w_rw) oProtocolError <= 1'b1;
            case (r_state)
                INIT_3A, INIT_3B, INIT_3C, INIT_2: begin
                    if (w_stb) begin
                        if (w_rs || r_d_s1 != ((r_state == INIT_2) ? 4'h2 : 4'h3)) begin
                            oProtocolError <= 1'b1;
                            r_state        <= INIT_3A;
                        end else begin
                            r_state <= lcd_state_t'(r_state + 3'd1);
                            if (r_state == INIT_2) oInitDone <= 1'b1;
                        end
                    end
                end
                HI_NIB: begin
                    if (w_stb) begin
                        r_hi    <= r_d_s1;
                        r_rs_hi <= w_rs;
                        r_state <= LO_NIB;
                    end
                end
                LO_NIB: begin
                    if (w_stb && !w_complete) begin
                        oProtocolError <= 1'b1;
                        r_state        <= HI_NIB;
                    end else if (w_complete) begin
                        oByteValid <= 1'b1;
                        oByte      <= w_byte;
                        oIsData    <= w_rs;
                        oBusy      <= 1'b1;
                        r_state    <= BUSY;
                        r_cnt      <= w_clr_cmd ? CW'(CLEAR_BUSY_CYCLES - 1) : CW'(CMD_BUSY_CYCLES - 1);
                        // Priority decode: the highest set bit of the command selects its class.
                        if (w_rs) begin
                            oDdramAddr <= next_addr(oDdramAddr, r_id);
                        end else if (w_byte >= CMD_SET_DDRAM) begin
                            oDdramAddr <= w_byte[6:0];
                            if ({1'b0, w_byte[5:0]} > WRAP_L1_END) oProtocolError <= 1'b1;
                        end else if (w_byte >= CMD_SET_CGRAM) begin
                            oDdramAddr <= oDdramAddr;
                        end else if (w_byte >= CMD_FUNC_SET) begin
                            if (w_byte[4]) oProtocolError <= 1'b1;
                        end else if (w_byte >= CMD_SHIFT) begin
                            oDdramAddr <= oDdramAddr;
                        end else if (w_byte >= CMD_DISP_CTRL) begin
                            oDispCtrl <= w_byte[2:0];
                        end else if (w_byte >= CMD_ENTRY_MODE) begin
                            r_id <= w_byte[1];
                        end else if (w_byte >= CMD_CLEAR) begin
                            oDdramAddr <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (w_stb) oProtocolError <= 1'b1;
                    if (r_cnt == '0) begin
                        oBusy   <= 1'b0;
                        r_state <= HI_NIB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= INIT_3A;
            endcase
        end
    end

`ifdef LCD_RESPONDER_FRAMEBUF_EN
    lcd_frame_buffer u_frame_buffer (
        .i_clk     (Clock),
        .i_we      (w_we),
        .i_addr    (oDdramAddr),
        .i_data    (w_byte),
        .i_clear   (w_clear),
        .i_rd_addr (iRdAddr),
        .o_rd_char (oRdChar)
    );
`else
    logic w_unused;
    assign w_unused = ^{iRdAddr, w_we, w_clear};
    assign oRdChar  = 8'h00;
`endif
endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: randomized self-checking bench for lcd_responder against a behavioural model.
// Busy times are scaled down (CMD=20, CLEAR=60) so the run stays short.
// Buffer checks run only when LCD_RESPONDER_FRAMEBUF_EN is defined.
module tb_lcd_responder;
    localparam int CMD = 20;
    localparam int CLR = 60;

    logic       Clock = 0, Reset = 0, e_i = 0, rs_i = 0, rw_i = 0;
    logic [3:0] d_i = 0;
    logic [4:0] rd_addr = 0;
    logic       oByteValid, oIsData, oBusy, oInitDone, oProtocolError;
    logic [7:0] oByte, oRdChar;
    logic [6:0] oDdramAddr;
    logic [2:0] oDispCtrl;

    int pass_cnt = 0, total = 0, vcnt = 0, cur_busy = 0, last_busy = 0;
    logic [7:0] vbyte = 0;
    logic       vdata = 0;

    int         m_addr;
    bit         m_id;
    logic [2:0] m_disp;
    logic [7:0] m_buf [32];

    lcd_responder #(.CMD_BUSY_CYCLES(CMD), .CLEAR_BUSY_CYCLES(CLR)) dut (
        .Clock(Clock), .Reset(Reset), .iLCD_Enabled(e_i), .iLCD_RegisterSelect(rs_i),
        .iLCD_ReadWrite(rw_i), .iLCD_Data(d_i), .oByteValid(oByteValid), .oByte(oByte),
        .oIsData(oIsData), .oDdramAddr(oDdramAddr), .oBusy(oBusy), .oInitDone(oInitDone),
        .oDispCtrl(oDispCtrl), .oProtocolError(oProtocolError), .iRdAddr(rd_addr), .oRdChar(oRdChar)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (oByteValid) begin
            vcnt++;
            vbyte = oByte;
            vdata = oIsData;
        end
        if (oBusy) cur_busy++;
        else if (cur_busy > 0) begin
            last_busy = cur_busy;
            cur_busy  = 0;
        end
    end

    // Display positions form a ring of 80: line 1 is 0..39, line 2 is 40..79 (addresses 0x40..0x67).
    function automatic int step(int a, bit inc);
        int p = (a < 64) ? a : a - 24;
        p = (p + (inc ? 1 : 79)) % 80;
        return (p < 40) ? p : p + 24;
    endfunction

    function automatic int slot(int a);
        return (a < 16) ? a : (a >= 64 && a < 80) ? a - 48 : -1;
    endfunction

    function automatic int model_byte(bit rs, logic [7:0] b);
        int hb = (b == 0) ? -1 : $clog2(int'(b) + 1) - 1;
        if (rs) begin
            if (slot(m_addr) >= 0) m_buf[slot(m_addr)] = b;
            m_addr = step(m_addr, m_id);
            return CMD;
        end
        case (hb)
            7: m_addr = int'(b[6:0]);
            3: m_disp = b[2:0];
            2: m_id = b[1];
            1: m_addr = 0;
            0: begin
                m_addr = 0;
                foreach (m_buf[i]) m_buf[i] = 8'h20;
            end
            default: ;
        endcase
        return (hb == 0 || hb == 1) ? CLR : CMD;
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic nib(input logic rs, input logic [3:0] d, input logic rw = 1'b0);
        @(negedge Clock);
        rs_i = rs; rw_i = rw; d_i = d; e_i = 1;
        tick(4);
        e_i = 0;
        tick(4);
    endtask

    task automatic wait_idle(output int busy);
        int n = 0;
        while (oBusy && n < 1000) begin
            tick(1);
            n++;
        end
        if (n >= 1000) begin
            total++;
            $display("FAIL busy_timeout: oBusy=%b after %0d cycles, want 0", oBusy, n);
        end
        tick(1);
        busy = last_busy;
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, output int busy);
        last_busy = 0;
        nib(rs, b[7:4]);
        nib(rs, b[3:0]);
        wait_idle(busy);
    endtask

    task automatic do_reset();
        e_i = 0; rs_i = 0; rw_i = 0; d_i = 0;
        Reset = 0;
        tick(3);
        Reset = 1;
        tick(2);
    endtask

    task automatic do_init();
        nib(0, 4'h3); nib(0, 4'h3); nib(0, 4'h3); nib(0, 4'h2);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({oByteValid, oByte, oIsData, oDdramAddr, oBusy} !== 18'h0) $display("FAIL reset_out: got %h want 0", {oByteValid, oByte, oIsData, oDdramAddr, oBusy}); else pass_cnt++;
        total++; if ({oInitDone, oDispCtrl, oProtocolError} !== 5'h0) $display("FAIL reset_flags: got %h want 0", {oInitDone, oDispCtrl, oProtocolError}); else pass_cnt++;
`ifndef LCD_RESPONDER_FRAMEBUF_EN
        total++; if (oRdChar !== 8'h00) $display("FAIL rdchar_tied: got %h want 00", oRdChar); else pass_cnt++;
`endif
    endtask

    task automatic test_init_ok();
        do_reset();
        do_init();
        total++; if (oInitDone !== 1'b1) $display("FAIL init_done: got %b want 1", oInitDone); else pass_cnt++;
        total++; if (oProtocolError !== 1'b0) $display("FAIL init_err: got %b want 0", oProtocolError); else pass_cnt++;
    endtask

    task automatic test_init_bad();
        do_reset();
        nib(0, 4'h3); nib(0, 4'h3); nib(0, 4'h2);
        total++; if (oProtocolError !== 1'b1) $display("FAIL init_bad_err: got %b want 1", oProtocolError); else pass_cnt++;
        total++; if (oInitDone !== 1'b0) $display("FAIL init_bad_done: got %b want 0", oInitDone); else pass_cnt++;
        do_init();
        total++; if (oInitDone !== 1'b1) $display("FAIL init_restart: got %b want 1", oInitDone); else pass_cnt++;
    endtask

    task automatic test_cmd_seq();
        logic [7:0] seq [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
        int busy;
        do_reset();
        do_init();
        for (int i = 0; i < 4; i++) begin
            int v0 = vcnt;
            send_byte(0, seq[i], busy);
            total++; if (vcnt != v0 + 1 || vbyte !== seq[i] || vdata !== 1'b0) $display("FAIL cmd_byte%0d: got n=%0d %h rs=%b want n=1 %h rs=0", i, vcnt - v0, vbyte, vdata, seq[i]); else pass_cnt++;
            total++; if (busy != ((seq[i] == 8'h01) ? CLR : CMD)) $display("FAIL cmd_busy%0d: got %0d want %0d", i, busy, (seq[i] == 8'h01) ? CLR : CMD); else pass_cnt++;
        end
        total++; if (oDispCtrl !== 3'b100) $display("FAIL cmd_disp: got %b want 100", oDispCtrl); else pass_cnt++;
        total++; if (oDdramAddr !== 7'h00 || oProtocolError !== 1'b0) $display("FAIL cmd_addr_err: got %h/%b want 00/0", oDdramAddr, oProtocolError); else pass_cnt++;
    endtask

    task automatic test_addr_data();
        int busy, v0;
        do_reset();
        do_init();
        send_byte(0, 8'hA7, busy);
        v0 = vcnt;
        send_byte(1, 8'h41, busy);
        total++; if (oDdramAddr !== 7'h40) $display("FAIL a7_addr: got %h want 40", oDdramAddr); else pass_cnt++;
        total++; if (vcnt != v0 + 1 || vbyte !== 8'h41 || vdata !== 1'b1) $display("FAIL a7_data: got n=%0d %h rs=%b want n=1 41 rs=1", vcnt - v0, vbyte, vdata); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [7:0] set_cmd [4] = '{8'hA7, 8'hE7, 8'hC0, 8'h80};
        logic [6:0] want [4] = '{7'h40, 7'h00, 7'h27, 7'h67};
        int busy;
        do_reset();
        do_init();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) send_byte(0, 8'h04, busy);
            send_byte(0, set_cmd[i], busy);
            send_byte(1, 8'h2A, busy);
            total++; if (oDdramAddr !== want[i]) $display("FAIL wrap%0d: got %h want %h", i, oDdramAddr, want[i]); else pass_cnt++;
        end
        total++; if (oProtocolError !== 1'b0) $display("FAIL wrap_err: got %b want 0", oProtocolError); else pass_cnt++;
    endtask

    task automatic test_busy_strobe();
        int busy, v0;
        do_reset();
        do_init();
        v0 = vcnt;
        last_busy = 0;
        nib(1, 4'h4); nib(1, 4'h1);
        nib(0, 4'h3);
        wait_idle(busy);
        total++; if (oProtocolError !== 1'b1) $display("FAIL busy_strobe_err: got %b want 1", oProtocolError); else pass_cnt++;
        total++; if (vcnt != v0 + 1) $display("FAIL busy_strobe_drop: got %0d pulses want 1", vcnt - v0); else pass_cnt++;
        send_byte(1, 8'h5A, busy);
        total++; if (vcnt != v0 + 2 || vbyte !== 8'h5A) $display("FAIL busy_resume: got n=%0d %h want n=2 5a", vcnt - v0, vbyte); else pass_cnt++;
    endtask

    task automatic test_rs_rw_errors();
        int busy, v0;
        do_reset();
        do_init();
        v0 = vcnt;
        nib(0, 4'h4); nib(1, 4'h1);
        total++; if (oProtocolError !== 1'b1 || vcnt != v0) $display("FAIL rs_mismatch: got err=%b n=%0d want err=1 n=0", oProtocolError, vcnt - v0); else pass_cnt++;
        nib(0, 4'h7, 1'b1);
        send_byte(1, 8'h33, busy);
        total++; if (vcnt != v0 + 1 || vbyte !== 8'h33 || vdata !== 1'b1) $display("FAIL rw_ignored: got n=%0d %h want n=1 33", vcnt - v0, vbyte); else pass_cnt++;
        do_reset();
        nib(0, 4'h3, 1'b1);
        total++; if (oProtocolError !== 1'b1) $display("FAIL rw_err: got %b want 1", oProtocolError); else pass_cnt++;
        do_init();
        total++; if (oInitDone !== 1'b1) $display("FAIL rw_init: got %b want 1", oInitDone); else pass_cnt++;
        do_reset();
        do_init();
        send_byte(0, 8'hA8, busy);
        total++; if (oProtocolError !== 1'b1 || oDdramAddr !== 7'h28) $display("FAIL bad_addr: got err=%b %h want 1 28", oProtocolError, oDdramAddr); else pass_cnt++;
        do_reset();
        do_init();
        send_byte(0, 8'h38, busy);
        total++; if (oProtocolError !== 1'b1) $display("FAIL func_dl: got %b want 1", oProtocolError); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int busy, v0;
        do_reset();
        do_init();
        nib(1, 4'h4);
        #2 Reset = 0;
        #1;
        total++; if (oInitDone !== 1'b0) $display("FAIL async_reset: got %b want 0", oInitDone); else pass_cnt++;
        tick(2);
        Reset = 1;
        do_init();
        v0 = vcnt;
        send_byte(1, 8'h41, busy);
        total++; if (vcnt != v0 + 1 || vbyte !== 8'h41 || oDdramAddr !== 7'h01) $display("FAIL reset_partial: got n=%0d %h addr %h want n=1 41 01", vcnt - v0, vbyte, oDdramAddr); else pass_cnt++;
        nib(0, 4'h0); nib(0, 4'h1);
        tick(5);
        #2 Reset = 0;
        #1;
        total++; if (oBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", oBusy); else pass_cnt++;
        tick(2);
        Reset = 1;
        wait_idle(busy);
    endtask

    task automatic test_random();
        int busy, expb, v0;
        logic rs;
        logic [7:0] b;
        do_reset();
        do_init();
        m_addr = 0; m_id = 1; m_disp = 0;
        for (int n = 0; n < 40; n++) begin
            rs = 0;
            if (n == 0) b = 8'h01;
            else case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin rs = 1; b = 8'($urandom_range(32, 126)); end
                5: b = 8'(128 + $urandom_range(0, 1) * 64 + $urandom_range(0, 39));
                6: b = 8'(4 + $urandom_range(0, 3));
                7: b = 8'(8 + $urandom_range(0, 7));
                8: b = 8'($urandom_range(1, 3));
                default: b = 8'(($urandom_range(0, 1) ? 16 : 64) + $urandom_range(0, 15));
            endcase
            v0 = vcnt;
            expb = model_byte(rs, b);
            send_byte(rs, b, busy);
            total++; if (vcnt != v0 + 1 || vbyte !== b || vdata !== rs) $display("FAIL rnd%0d_byte: got n=%0d %h rs=%b want n=1 %h rs=%b", n, vcnt - v0, vbyte, vdata, b, rs); else pass_cnt++;
            total++; if (busy != expb) $display("FAIL rnd%0d_busy: got %0d want %0d", n, busy, expb); else pass_cnt++;
            total++; if (oDdramAddr !== 7'(m_addr) || oDispCtrl !== m_disp) $display("FAIL rnd%0d_state: got %h/%b want %h/%b", n, oDdramAddr, oDispCtrl, 7'(m_addr), m_disp); else pass_cnt++;
        end
        total++; if (oProtocolError !== 1'b0) $display("FAIL rnd_err: got %b want 0", oProtocolError); else pass_cnt++;
`ifdef LCD_RESPONDER_FRAMEBUF_EN
        for (int i = 0; i < 32; i++) begin
            @(negedge Clock);
            rd_addr = 5'(i);
            tick(2);
            total++; if (oRdChar !== m_buf[i]) $display("FAIL buf%0d: got %h want %h", i, oRdChar, m_buf[i]); else pass_cnt++;
        end
`endif
    endtask

    task automatic test_framebuf();
`ifdef LCD_RESPONDER_FRAMEBUF_EN
        int busy;
        do_reset();
        do_init();
        send_byte(0, 8'hCF, busy);
        send_byte(1, 8'h48, busy);
        @(negedge Clock);
        rd_addr = 5'd31;
        tick(1);
        total++; if (oRdChar !== 8'h48) $display("FAIL buf_4f: got %h want 48", oRdChar); else pass_cnt++;
`else
        total++; if (oRdChar !== 8'h00) $display("FAIL rdchar_zero: got %h want 00", oRdChar); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_init_ok();
        test_init_bad();
        test_cmd_seq();
        test_addr_data();
        test_wrap();
        test_busy_strobe();
        test_rs_rw_errors();
        test_reset_mid();
        test_random();
        test_framebuf();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
